// File: rtl/nonce_serial_tx.sv
// Serialises a 32-bit golden nonce onto a UART line as four 8N1 frames.
// The frames go out little-endian, LSB first, with no gaps between them.
module nonce_serial_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        hash_clk,
  input  logic        rst_n,
  input  logic [31:0] golden_nonce,
  input  logic        serial_send,
  output logic        serial_busy,
  output logic        uart_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   shift_reg;
  logic          bit_end;

  assign bit_end     = (baud_cnt == BAUD_MAX);
  assign serial_busy = (state != IDLE) || serial_send;

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (serial_send) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (bit_end) state_next = (byte_idx == 2'd3) ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // The shift register drops one bit per data bit, so once a byte has been
  // sent the next byte is already sitting in the low bits.
  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (serial_send) begin
            shift_reg <= golden_nonce;
            byte_idx  <= '0;
            bit_idx   <= '0;
            uart_tx   <= 1'b0;
          end else begin
            uart_tx <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            uart_tx   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              uart_tx   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx == 2'd3) begin
              uart_tx <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              uart_tx  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          baud_cnt <= '0;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_serial_tx.sv
// Directed bench for nonce_serial_tx with a mid-bit UART receiver.
// The receiver checks the bytes it decodes against a scoreboard queue.
module tb_nonce_serial_tx;

  localparam int CPB = 4;

  logic        hash_clk;
  logic        rst_n;
  logic [31:0] golden_nonce;
  logic        serial_send;
  logic        serial_busy;
  logic        uart_tx;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  int          starts[$];

  nonce_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .hash_clk     (hash_clk),
    .rst_n        (rst_n),
    .golden_nonce (golden_nonce),
    .serial_send  (serial_send),
    .serial_busy  (serial_busy),
    .uart_tx      (uart_tx)
  );

  initial begin
    hash_clk = 1'b0;
    forever #5 hash_clk = ~hash_clk;
  end

  initial forever begin
    @(posedge hash_clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Mid-bit receiver; also requires every sample of a bit period to match its first sample.
  initial begin
    bit        mon_active = 1'b0;
    int        mon_phase  = 0;
    int        mon_bit    = 0;
    logic      mon_ref    = 1'b1;
    logic [7:0] mon_byte  = '0;
    logic [7:0] exp_byte;
    forever begin
      @(negedge hash_clk);
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && uart_tx === 1'b0) begin
          mon_active = 1'b1;
          mon_phase  = 0;
          mon_bit    = 0;
          starts.push_back(cyc);
        end
        if (mon_active) begin
          if (mon_phase == 0) mon_ref = uart_tx;
          else check_output("bit_period", 32'(uart_tx), 32'(mon_ref));
          if (mon_phase == CPB / 2) begin
            if (mon_bit == 0)      check_output("start_bit", 32'(uart_tx), 32'd0);
            else if (mon_bit == 9) check_output("stop_bit", 32'(uart_tx), 32'd1);
            else                   mon_byte[mon_bit-1] = uart_tx;
          end
          if (mon_phase == CPB - 1) begin
            mon_phase = 0;
            if (mon_bit == 9) begin
              mon_active = 1'b0;
              check_output("rx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
              if (exp_q.size() != 0) begin
                exp_byte = exp_q.pop_front();
                check_output("rx_byte", 32'(mon_byte), 32'(exp_byte));
              end
            end else begin
              mon_bit++;
            end
          end else begin
            mon_phase++;
          end
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic apply_stimulus(input logic [31:0] w);
    @(negedge hash_clk);
    golden_nonce = w;
    serial_send  = 1'b1;
    #1 check_output("busy_same_cycle", 32'(serial_busy), 32'd1);
    push_word(w);
    @(posedge hash_clk);
    #1 check_output("tx_start_at_accept", 32'(uart_tx), 32'd0);
    serial_send = 1'b0;
  endtask

  // Counts busy samples after the accept edge; optionally pulses a request mid-word.
  task automatic run_until_idle(input int pulse_at, input logic [31:0] pulse_val, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge hash_clk);
      if (serial_busy !== 1'b1) break;
      n++;
      if (i == pulse_at) begin
        golden_nonce = pulse_val;
        serial_send  = 1'b1;
      end else if (i == pulse_at + 1) begin
        serial_send = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    int diff;
    rst_n        = 1'b0;
    serial_send  = 1'b0;
    golden_nonce = '0;

    repeat (3) @(negedge hash_clk);
    check_output("reset_tx", 32'(uart_tx), 32'd1);
    check_output("reset_busy", 32'(serial_busy), 32'd0);
    serial_send = 1'b1;
    #1 check_output("reset_busy_follows_send", 32'(serial_busy), 32'd1);
    serial_send = 1'b0;
    @(negedge hash_clk);
    rst_n = 1'b1;

    $display("[TB] single word");
    apply_stimulus(32'h12345678);
    run_until_idle(-1, 32'h0, n);
    check_output("busy_cycles_single", 32'(n), 32'd160);
    check_output("idle_tx_single", 32'(uart_tx), 32'd1);
    check_output("idle_busy_single", 32'(serial_busy), 32'd0);

    $display("[TB] dropped request");
    apply_stimulus(32'hAAAAAAAA);
    run_until_idle(50, 32'h55555555, n);
    check_output("busy_cycles_dropped", 32'(n), 32'd160);
    check_output("idle_tx_dropped", 32'(uart_tx), 32'd1);

    $display("[TB] back-to-back");
    repeat (3) @(negedge hash_clk);
    starts.delete();
    golden_nonce = 32'h00000001;
    serial_send  = 1'b1;
    push_word(32'h00000001);
    push_word(32'hFFFFFFFF);
    @(posedge hash_clk);
    #1 check_output("tx_start_word1", 32'(uart_tx), 32'd0);
    golden_nonce = 32'hFFFFFFFF;
    repeat (160) @(posedge hash_clk);
    @(posedge hash_clk);
    #1 check_output("tx_start_word2", 32'(uart_tx), 32'd0);
    serial_send = 1'b0;
    run_until_idle(-1, 32'h0, n);
    check_output("busy_cycles_b2b", 32'(n), 32'd160);
    check_output("frame_count_b2b", 32'(starts.size()), 32'd8);
    for (int i = 1; i < starts.size(); i++) begin
      diff = starts[i] - starts[i-1];
      if (i % 4 != 0) check_output("frame_spacing", 32'(diff), 32'(10 * CPB));
      else check_output("word_gap", 32'(diff >= 10 * CPB && diff <= 10 * CPB + 1), 32'd1);
    end

    $display("[TB] reset mid-word");
    apply_stimulus(32'h13579BDF);
    repeat (70) @(posedge hash_clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_output("abort_tx", 32'(uart_tx), 32'd1);
    check_output("abort_busy", 32'(serial_busy), 32'd0);
    repeat (2) @(negedge hash_clk);
    rst_n = 1'b1;
    apply_stimulus(32'hDEADBEEF);
    run_until_idle(-1, 32'h0, n);
    check_output("busy_cycles_after_reset", 32'(n), 32'd160);
    repeat (5) @(negedge hash_clk);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
